hangman_datapath: RTL and testbench

Datapath responder for the hangman game controller FSM. It consumes the controller's command levels (`ld`, `ldgraph`, `timecount`, `ldguessinput`, `compare`, `fill`, `draw`, `over`, `address`) and returns the status flags the FSM branches on (`match`, `filled`, `continuous`, `complete`, `timeout`). It also holds the secret word, the revealed-letter mask, the miss count and the round timer, and exports them to the VGA/HEX display logic.

---
 rtl/hangman_datapath.sv | 189 ++++++++++++++++++
 tb/tb_hangman_datapath.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hangman_datapath.sv
// hangman_datapath
// Datapath behind the hangman controller FSM. It stores the secret word, the
// current guess, the revealed-letter mask, the miss count and the round timer.
// It returns the status flags the FSM branches on.
//
// Ports:
//   clk, resetn            clock; synchronous active-high reset
//   ld, address            word load enable and write address
//   char_in, char_valid    keyboard character and its one-cycle strobe
//   ldgraph                start a new round (clears round state, keeps word)
//   timecount              round timer run enable
//   ldguessinput           guess load enable
//   compare                compare phase (informational only)
//   fill                   reveal matched letters (handshake with filled)
//   draw                   record a miss (rising edge counts)
//   over                   round over: freezes fill, draw and timer state
//   match                  guess hits at least one unrevealed position
//   filled                 reveal update done
//   continuous             at least one position still hidden
//   complete               miss limit reached, including the miss being drawn
//   timeout                round time expired
//   word_len, revealed, miss_count, time_left   display exports
//
// Handshakes: fill/filled is a level handshake. The first cycle of fill
// updates the mask and raises filled. filled stays high while fill is held
// and drops the cycle after fill is released.
module hangman_datapath #(
  parameter int ADDR_W        = 5,
  parameter int MAX_MISSES    = 6,
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TIME_LIMIT    = 60
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ld,
  input  logic [ADDR_W-1:0]     address,
  input  logic [7:0]            char_in,
  input  logic                  char_valid,
  input  logic                  ldgraph,
  input  logic                  timecount,
  input  logic                  ldguessinput,
  input  logic                  compare,
  input  logic                  fill,
  input  logic                  draw,
  input  logic                  over,
  output logic                  match,
  output logic                  filled,
  output logic                  continuous,
  output logic                  complete,
  output logic                  timeout,
  output logic [ADDR_W:0]       word_len,
  output logic [2**ADDR_W-1:0]  revealed,
  output logic [2:0]            miss_count,
  output logic [7:0]            time_left
);

  localparam int MAX_LEN = 2**ADDR_W;
  localparam int PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    TL         = 8'(TIME_LIMIT);
  localparam logic [2:0]    MM         = 3'(MAX_MISSES);

  logic [7:0]         word_q [MAX_LEN];
  logic [7:0]         word_d [MAX_LEN];
  logic [ADDR_W:0]    word_len_q, word_len_d;
  logic [7:0]         guess_q, guess_d;
  logic [MAX_LEN-1:0] revealed_q, revealed_d;
  logic [2:0]         miss_q, miss_d;
  logic               draw_prev_q, draw_prev_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [7:0]         time_left_q, time_left_d;
  logic               timeout_q, timeout_d;
  logic               filled_q, filled_d;

  logic [MAX_LEN-1:0] hit;
  logic [MAX_LEN-1:0] lenmask;
  logic               draw_rise;
  logic               unused_compare;

  assign unused_compare = compare;

  // Positions inside the word that hold the guess and are not yet shown.
  always_comb begin
    hit     = '0;
    lenmask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      lenmask[i] = (i < 32'(word_len_q));
      hit[i]     = lenmask[i] && (word_q[i] == guess_q) && !revealed_q[i];
    end
  end

  assign draw_rise  = draw && !draw_prev_q;
  assign match      = |hit;
  assign continuous = |(~revealed_q & lenmask);
  // The edge term lets the FSM see completion in the draw cycle itself.
  assign complete   = (miss_q >= MM) || (draw_rise && (miss_q == MM - 3'd1));

  always_comb begin
    word_d      = word_q;
    word_len_d  = word_len_q;
    guess_d     = guess_q;
    revealed_d  = revealed_q;
    miss_d      = miss_q;
    draw_prev_d = draw;
    presc_d     = presc_q;
    time_left_d = time_left_q;
    timeout_d   = timeout_q;
    filled_d    = filled_q;
    if (ldgraph) begin
      revealed_d  = '0;
      miss_d      = '0;
      presc_d     = '0;
      time_left_d = TL;
      timeout_d   = 1'b0;
      filled_d    = 1'b0;
    end else begin
      if (ld && char_valid) begin
        word_d[address] = char_in;
        word_len_d      = {1'b0, address} + (ADDR_W+1)'(1);
      end
      if (ldguessinput && char_valid) begin
        guess_d = char_in;
      end
      if (!over) begin
        if (fill && !filled_q) begin
          revealed_d = revealed_q | hit;
          filled_d   = 1'b1;
        end else begin
          filled_d = fill;
        end
        if (draw_rise && (miss_q < MM)) begin
          miss_d = miss_q + 3'd1;
        end
        if (timecount && !timeout_q) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (time_left_q != 8'd0) begin
              time_left_d = time_left_q - 8'd1;
            end
            // Raise timeout on the same edge that the count reaches zero.
            if (time_left_q <= 8'd1) begin
              timeout_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        word_q[i] <= 8'h00;
      end
      word_len_q  <= '0;
      guess_q     <= 8'h00;
      revealed_q  <= '0;
      miss_q      <= '0;
      draw_prev_q <= 1'b0;
      presc_q     <= '0;
      time_left_q <= TL;
      timeout_q   <= 1'b0;
      filled_q    <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        word_q[i] <= word_d[i];
      end
      word_len_q  <= word_len_d;
      guess_q     <= guess_d;
      revealed_q  <= revealed_d;
      miss_q      <= miss_d;
      draw_prev_q <= draw_prev_d;
      presc_q     <= presc_d;
      time_left_q <= time_left_d;
      timeout_q   <= timeout_d;
      filled_q    <= filled_d;
    end
  end

  assign filled     = filled_q;
  assign timeout    = timeout_q;
  assign word_len   = word_len_q;
  assign revealed   = revealed_q;
  assign miss_count = miss_q;
  assign time_left  = time_left_q;

endmodule

// File: tb/tb_hangman_datapath.sv
// Testbench for hangman_datapath: directed stimulus, a game-level reference
// model checked every cycle, and literal expectations for key scenarios.
module tb_hangman_datapath;

  localparam int ADDR_W  = 5;
  localparam int MAXLEN  = 32;
  localparam int TPS     = 4;
  localparam int TLIM    = 3;
  localparam int MAXMISS = 6;

  logic              clk = 1'b0;
  logic              resetn, ld, char_valid, ldgraph, timecount;
  logic              ldguessinput, compare, fill, draw, over;
  logic [ADDR_W-1:0] address;
  logic [7:0]        char_in;
  logic              match, filled, continuous, complete, timeout;
  logic [ADDR_W:0]   word_len;
  logic [MAXLEN-1:0] revealed;
  logic [2:0]        miss_count;
  logic [7:0]        time_left;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  hangman_datapath #(
    .ADDR_W(ADDR_W), .MAX_MISSES(MAXMISS),
    .TICKS_PER_SEC(TPS), .TIME_LIMIT(TLIM)
  ) dut (
    .clk(clk), .resetn(resetn), .ld(ld), .address(address),
    .char_in(char_in), .char_valid(char_valid), .ldgraph(ldgraph),
    .timecount(timecount), .ldguessinput(ldguessinput), .compare(compare),
    .fill(fill), .draw(draw), .over(over), .match(match), .filled(filled),
    .continuous(continuous), .complete(complete), .timeout(timeout),
    .word_len(word_len), .revealed(revealed), .miss_count(miss_count),
    .time_left(time_left)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (game level) ----------------
  byte unsigned m_word [MAXLEN];
  int           m_len;
  byte unsigned m_guess;
  bit           m_rev [MAXLEN];
  int           m_miss;
  bit           m_prev_draw;
  bit           m_filled;
  int           m_ticks;   // counted timer cycles since round start

  function automatic bit m_hit(int i);
    return (i < m_len) && (m_word[i] == m_guess) && !m_rev[i];
  endfunction

  always @(posedge clk) begin
    bit h [MAXLEN];
    for (int i = 0; i < MAXLEN; i++) h[i] = m_hit(i);
    if (resetn) begin
      for (int i = 0; i < MAXLEN; i++) begin m_word[i] = 0; m_rev[i] = 0; end
      m_len = 0; m_guess = 0; m_miss = 0; m_prev_draw = 0;
      m_filled = 0; m_ticks = 0;
    end else if (ldgraph) begin
      for (int i = 0; i < MAXLEN; i++) m_rev[i] = 0;
      m_miss = 0; m_ticks = 0; m_filled = 0;
      m_prev_draw = draw;
    end else begin
      if (ld && char_valid) begin
        m_word[address] = char_in;
        m_len = int'(address) + 1;
      end
      if (ldguessinput && char_valid) m_guess = char_in;
      if (!over) begin
        if (fill && !m_filled) begin
          for (int i = 0; i < MAXLEN; i++) if (h[i]) m_rev[i] = 1;
          m_filled = 1;
        end else begin
          m_filled = fill;
        end
        if (draw && !m_prev_draw && m_miss < MAXMISS) m_miss++;
        if (timecount && m_ticks < TLIM * TPS) m_ticks++;
      end
      m_prev_draw = draw;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit e_match, e_cont;
      logic [31:0] e_rev;
      e_match = 0; e_cont = 0; e_rev = '0;
      for (int i = 0; i < MAXLEN; i++) begin
        if (m_hit(i)) e_match = 1;
        if (i < m_len && !m_rev[i]) e_cont = 1;
        e_rev[i] = m_rev[i];
      end
      check("m_match", 32'(match), 32'(e_match));
      check("m_continuous", 32'(continuous), 32'(e_cont));
      check("m_complete", 32'(complete),
            32'((m_miss >= MAXMISS) || (draw && !m_prev_draw && m_miss == MAXMISS - 1)));
      check("m_filled", 32'(filled), 32'(m_filled));
      check("m_timeout", 32'(timeout), 32'(m_ticks == TLIM * TPS));
      check("m_time_left", 32'(time_left), 32'(TLIM - m_ticks / TPS));
      check("m_word_len", 32'(word_len), 32'(m_len));
      check("m_revealed", revealed, e_rev);
      check("m_miss_count", 32'(miss_count), 32'(m_miss));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_char(input int a, input byte unsigned c);
    ld = 1; address = ADDR_W'(a); char_in = c; char_valid = 1;
    tick();
    ld = 0; char_valid = 0;
  endtask

  task automatic guess(input byte unsigned c);
    ldguessinput = 1; char_in = c; char_valid = 1;
    tick();
    ldguessinput = 0; char_valid = 0;
  endtask

  task automatic fill_pulse();
    fill = 1; tick(); tick();
    fill = 0; tick();
  endtask

  task automatic round_start();
    ldgraph = 1; tick(); ldgraph = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    bit seen;
    resetn = 1; ld = 0; char_valid = 0; ldgraph = 0; timecount = 0;
    ldguessinput = 0; compare = 0; fill = 0; draw = 0; over = 0;
    address = '0; char_in = 8'h00;
    tick(); tick();
    resetn = 0;
    chk_en = 1;
    check("reset_word_len", 32'(word_len), 0);
    check("reset_time_left", 32'(time_left), 3);
    check("reset_continuous", 32'(continuous), 0);

    // Word load and first hit
    round_start();
    put_char(0, "C"); put_char(1, "A"); put_char(2, "T");
    check("cat_word_len", 32'(word_len), 3);
    guess("A");
    check("guess_a_match", 32'(match), 1);
    fill = 1; tick();
    check("fill_filled", 32'(filled), 1);
    check("fill_revealed", revealed, 32'b010);
    check("fill_continuous", 32'(continuous), 1);
    tick();
    check("fill_held", 32'(filled), 1);
    fill = 0; tick();
    check("fill_released", 32'(filled), 0);

    // Repeat guess of a shown letter
    guess("A");
    check("repeat_match", 32'(match), 0);

    // Miss on a letter not in the word
    guess("Q");
    check("miss_match", 32'(match), 0);

    // Win path
    guess("C"); fill_pulse();
    guess("T"); fill_pulse();
    check("win_revealed", revealed, 32'b111);
    check("win_continuous", 32'(continuous), 0);

    // Miss limit
    for (int k = 0; k < MAXMISS; k++) begin
      draw = 1; #1;
      check("draw_complete", 32'(complete), 32'(k == MAXMISS - 1));
      tick();
      draw = 0; tick();
    end
    check("miss_limit_count", 32'(miss_count), 6);
    check("miss_limit_complete", 32'(complete), 1);
    draw = 1; tick(); draw = 0; tick();
    check("miss_saturate", 32'(miss_count), 6);

    // Held draw counts once
    round_start();
    draw = 1; tick(); tick(); tick();
    draw = 0; tick();
    check("held_draw", 32'(miss_count), 1);

    // Over freezes the miss count
    over = 1;
    draw = 1; tick(); draw = 0; tick();
    check("over_draw", 32'(miss_count), 1);
    over = 0; tick();

    // Timer: timeout exactly TLIM*TPS cycles after round start
    ldgraph = 1; timecount = 1; tick(); ldgraph = 0;
    n = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick(); n++;
      if (timeout) seen = 1;
    end
    check("timeout_latency", 32'(n), 12);
    check("timeout_time_left", 32'(time_left), 0);
    tick(); tick();
    check("timeout_sticky", 32'(timeout), 1);

    // Timer pause
    round_start();
    repeat (5) tick();
    timecount = 0;
    repeat (6) tick();
    check("pause_time_left", 32'(time_left), 2);
    check("pause_timeout", 32'(timeout), 0);
    round_start();
    check("restart_time_left", 32'(time_left), 3);
    check("restart_timeout", 32'(timeout), 0);

    // Reset during fill
    guess("A");
    fill = 1; resetn = 1; tick();
    check("rst_filled", 32'(filled), 0);
    check("rst_revealed", revealed, 0);
    check("rst_word_len", 32'(word_len), 0);
    resetn = 0; fill = 0; tick();

    // Address 0 restarts the word
    put_char(0, "X"); put_char(1, "Y"); put_char(3, "Z");
    check("len_after_addr3", 32'(word_len), 4);
    put_char(0, "W");
    check("len_restart", 32'(word_len), 1);
    ld = 0; address = 5'd7; char_in = "K"; char_valid = 1; tick();
    char_valid = 0;
    check("ld_low_ignored", 32'(word_len), 1);
    guess("W");
    check("restart_match", 32'(match), 1);
    tick(); tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
